// File: rtl/fir_tap_sequencer.sv
// Purpose: programs NTAPS FIR coefficients, optionally flushes the delay line, then streams samples.
// Latency: tap writes and RUN samples appear 1 cycle after acceptance; FLUSH adds NTAPS zero cycles.
// Backpressure: o_coef_ready only in LOAD; samples arriving outside RUN are dropped and flagged.
// Build option: define FIR_TAP_FLUSH_EN to insert the FLUSH phase between LOAD and RUN.
module fir_tap_sequencer #(
  parameter int NTAPS = 85,
  parameter int TW    = 12,
  parameter int IW    = 12
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_load_start,
  input  logic          i_coef_valid,
  input  logic [TW-1:0] i_coef,
  output logic          o_coef_ready,
  input  logic          i_sample_valid,
  input  logic [IW-1:0] i_sample,
  output logic          o_tap_wr,
  output logic [TW-1:0] o_tap,
  output logic          o_ce,
  output logic [IW-1:0] o_sample,
  output logic          o_busy,
  output logic          o_loaded,
  output logic          o_drop
);

  localparam int CW = $clog2(NTAPS + 1);
  localparam logic [CW-1:0] LAST = CW'(NTAPS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            coef_acc;
  logic            run;

  logic            tap_wr_q;
  logic [TW-1:0]   tap_q;
  logic            ce_q;
  logic [IW-1:0]   sample_q;
  logic            drop_q;

  assign run      = (state_q == RUN);
  assign coef_acc = (state_q == LOAD) && i_coef_valid;

  // Next-state logic: cnt counts accepted taps in LOAD and zero cycles in FLUSH.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_load_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        // Start requests are ignored here, including alongside the final coefficient.
        if (coef_acc) begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
`ifdef FIR_TAP_FLUSH_EN
            state_d = FLUSH;
`else
            state_d = RUN;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (cnt_q == LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (i_load_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered datapath: tap write strobe/value, RUN sample pass-through, drop flag.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tap_wr_q <= 1'b0;
      tap_q    <= '0;
      ce_q     <= 1'b0;
      sample_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      tap_wr_q <= coef_acc;
      if (coef_acc) begin
        tap_q <= i_coef;
      end
      ce_q     <= run && i_sample_valid;
      // Zero outside RUN, so the first FLUSH cycle also presents a zero sample.
      sample_q <= run ? i_sample : '0;
      drop_q   <= i_sample_valid && !run;
    end
  end

  assign o_coef_ready = (state_q == LOAD);
  assign o_tap_wr     = tap_wr_q;
  assign o_tap        = tap_q;
  assign o_ce         = (state_q == FLUSH) || ce_q;
  assign o_sample     = (state_q == FLUSH) ? '0 : sample_q;
  assign o_busy       = (state_q == LOAD) || (state_q == FLUSH);
  assign o_loaded     = run;
  assign o_drop       = drop_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
module tb_fir_tap_sequencer;
  localparam int NTAPS = 85;
  localparam int TW    = 12;
  localparam int IW    = 12;
`ifdef FIR_TAP_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic          i_clk;
  logic          i_reset_n;
  logic          i_load_start;
  logic          i_coef_valid;
  logic [TW-1:0] i_coef;
  logic          o_coef_ready;
  logic          i_sample_valid;
  logic [IW-1:0] i_sample;
  logic          o_tap_wr;
  logic [TW-1:0] o_tap;
  logic          o_ce;
  logic [IW-1:0] o_sample;
  logic          o_busy;
  logic          o_loaded;
  logic          o_drop;

  fir_tap_sequencer #(.NTAPS(NTAPS), .TW(TW), .IW(IW)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_load_start   (i_load_start),
    .i_coef_valid   (i_coef_valid),
    .i_coef         (i_coef),
    .o_coef_ready   (o_coef_ready),
    .i_sample_valid (i_sample_valid),
    .i_sample       (i_sample),
    .o_tap_wr       (o_tap_wr),
    .o_tap          (o_tap),
    .o_ce           (o_ce),
    .o_sample       (o_sample),
    .o_busy         (o_busy),
    .o_loaded       (o_loaded),
    .o_drop         (o_drop)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: how many coefficients are still wanted, how many zero
  // cycles remain, whether live samples flow, plus last cycle's outputs.
  int            m_need;
  int            m_flush;
  bit            m_run;
  bit            m_wr;
  logic [TW-1:0] m_tap;
  bit            m_ce;
  logic [IW-1:0] m_smp;
  bit            m_drop;
  int            wr_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_need  = 0;
    m_flush = 0;
    m_run   = 0;
    m_wr    = 0;
    m_tap   = '0;
    m_ce    = 0;
    m_smp   = '0;
    m_drop  = 0;
    wr_seen = 0;
  endtask

  function automatic logic [TW-1:0] next_coef();
    return TW'(NTAPS - m_need + 1);
  endfunction

  task automatic check_outputs();
    chk("coef_ready", {31'd0, o_coef_ready}, {31'd0, m_need > 0});
    chk("busy",       {31'd0, o_busy},       {31'd0, (m_need > 0) || (m_flush > 0)});
    chk("loaded",     {31'd0, o_loaded},     {31'd0, m_run});
    chk("tap_wr",     {31'd0, o_tap_wr},     {31'd0, m_wr});
    chk("tap",        32'(o_tap),            32'(m_tap));
    chk("ce",         {31'd0, o_ce},         {31'd0, (m_flush > 0) || m_ce});
    if (m_flush > 0) chk("flush_sample", 32'(o_sample), 32'd0);
    else if (m_ce)   chk("run_sample",   32'(o_sample), 32'(m_smp));
    chk("drop",       {31'd0, o_drop},       {31'd0, m_drop});
  endtask

  // One clock cycle: check current outputs, apply inputs, advance the model.
  task automatic step(input bit ls, input bit cv, input logic [TW-1:0] cf,
                      input bit sv, input logic [IW-1:0] sm);
    bit acc;
    check_outputs();
    if (o_tap_wr) wr_seen++;
    i_load_start   = ls;
    i_coef_valid   = cv;
    i_coef         = cf;
    i_sample_valid = sv;
    i_sample       = sm;
    acc    = (m_need > 0) && cv;
    m_wr   = acc;
    if (acc) m_tap = cf;
    m_drop = sv && !m_run;
    m_ce   = m_run && sv;
    m_smp  = m_run ? sm : '0;
    if (m_need > 0) begin
      if (acc) begin
        m_need--;
        if (m_need == 0) begin
          if (FLUSH_EN) m_flush = NTAPS;
          else          m_run   = 1;
        end
      end
    end else if (m_flush > 0) begin
      m_flush--;
      if (m_flush == 0) m_run = 1;
    end else if (ls) begin
      m_run   = 0;
      m_need  = NTAPS;
      wr_seen = 0;
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic reset_check(input string tag);
    i_reset_n = 1'b0;
    i_load_start = 0; i_coef_valid = 0; i_coef = '0; i_sample_valid = 0; i_sample = '0;
    #1;
    chk({tag, "_ready"},  {31'd0, o_coef_ready}, 32'd0);
    chk({tag, "_tap_wr"}, {31'd0, o_tap_wr},     32'd0);
    chk({tag, "_tap"},    32'(o_tap),            32'd0);
    chk({tag, "_ce"},     {31'd0, o_ce},         32'd0);
    chk({tag, "_sample"}, 32'(o_sample),         32'd0);
    chk({tag, "_busy"},   {31'd0, o_busy},       32'd0);
    chk({tag, "_loaded"}, {31'd0, o_loaded},     32'd0);
    chk({tag, "_drop"},   {31'd0, o_drop},       32'd0);
    m_reset();
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  // Called right after the last coefficient was accepted: measure time to
  // o_loaded and zero-cycle count, while offering extra coefficients that
  // must be refused.
  task automatic finish_load(input string tag);
    int lat = 1;
    int ce_cnt = 0;
    while (!o_loaded && lat < 300) begin
      if (o_ce) ce_cnt++;
      step(0, 1, TW'($urandom), 1'($urandom), '0);
      lat++;
    end
    chk({tag, "_load_lat"}, lat, FLUSH_EN ? NTAPS + 1 : 1);
    chk({tag, "_flush_ce"}, ce_cnt, FLUSH_EN ? NTAPS : 0);
    step(0, 1, TW'($urandom), 0, '0);
    chk({tag, "_nwr"}, wr_seen, NTAPS);
  endtask

  initial begin
    int guard;
    i_reset_n = 1'b0;
    m_reset();
    #2;
    reset_check("por");

    // Full load with coefficient valid held high.
    step(1, 0, '0, 0, '0);
    guard = 0;
    while (m_need > 0 && guard < 400) begin
      step(0, 1, next_coef(), 1'($urandom), IW'($urandom));
      guard++;
    end
    chk("held_load_cycles", guard, NTAPS);
    finish_load("held");

    // Live samples of 0x7FF every cycle, then reload with toggling valid.
    for (int i = 0; i < 10; i++) step(0, 0, '0, 1, 12'h7FF);
    step(1, 0, '0, 1, 12'h7FF);
    guard = 0;
    while (m_need > 0 && guard < 400) begin
      step(0, guard[0], next_coef(), 1, 12'h7FF);
      guard++;
    end
    chk("toggle_load_cycles", guard, 2 * NTAPS);
    finish_load("toggle");
    for (int i = 0; i < 5; i++) step(0, 0, '0, 1, IW'($urandom));

    // Reset after 40 coefficients, then a complete load with random valid.
    step(1, 0, '0, 1'($urandom), '0);
    guard = 0;
    while (m_need > NTAPS - 40 && guard < 400) begin
      step(0, 1'($urandom), next_coef(), 1'($urandom), IW'($urandom));
      guard++;
    end
    chk("part_load_need", m_need, NTAPS - 40);
    #2;
    reset_check("mid");
    for (int i = 0; i < 3; i++) step(0, 1, 12'hABC, 1'($urandom), '0);
    step(1, 0, '0, 0, '0);
    guard = 0;
    while (m_need > 0 && guard < 1000) begin
      step(0, 1'($urandom), next_coef(), 1'($urandom), IW'($urandom));
      guard++;
    end
    chk("rand_load_done", m_need, 0);
    finish_load("reload");

    // Free-running random traffic including occasional restarts.
    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, TW'($urandom),
           1'($urandom), IW'($urandom));
    end
    check_outputs();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/fir_tap_sequencer.md
FIR_TAP_SEQUENCER -- requirements
Module: fir_tap_sequencer

Interface
REQ-001 SHALL have parameter NTAPS, default 85, number of FIR taps to program.
REQ-002 SHALL have parameter TW, default 12, coefficient width in bits.
REQ-003 SHALL have parameter IW, default 12, sample width in bits.
REQ-004 SHALL have a single clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of i_clk.
REQ-005 i_clk  input  1  sole clock.
REQ-006 i_reset_n  input  1  async active-low reset.
REQ-007 i_load_start  input  1  single-cycle request to (re)program all taps.
REQ-008 i_coef_valid  input  1  coefficient source has a word.
REQ-009 i_coef  input  TW  coefficient word, tap 0 first.
REQ-010 o_coef_ready  output  1  sequencer accepts a coefficient this cycle.
REQ-011 i_sample_valid  input  1  upstream sample strobe.
REQ-012 i_sample  input  IW  upstream sample.
REQ-013 o_tap_wr  output  1  tap-write strobe to FIR.
REQ-014 o_tap  output  TW  tap value to FIR.
REQ-015 o_ce  output  1  clock-enable/sample strobe to FIR.
REQ-016 o_sample  output  IW  sample to FIR.
REQ-017 o_busy  output  1  high while state is LOAD or FLUSH.
REQ-018 o_loaded  output  1  taps valid and FIR fed with live samples.
REQ-019 o_drop  output  1  one-cycle pulse: an input sample was discarded.

Function
REQ-020 States SHALL be IDLE, LOAD, FLUSH, RUN; counter width clog2(NTAPS+1).
REQ-021 IDLE: o_ce=0, o_coef_ready=0; i_load_start -> LOAD next cycle, counter cleared.
REQ-022 LOAD: o_coef_ready=1 combinationally; each cycle with i_coef_valid&&o_coef_ready, o_tap_wr=1 and o_tap=i_coef registered one cycle later, counter +1.
REQ-023 After the NTAPS-th accepted coefficient, state SHALL move to FLUSH on the next edge and o_coef_ready SHALL be 0 from that cycle on; no coefficient beyond NTAPS is accepted.
REQ-024 o_tap_wr SHALL be 0 in every cycle not following an accepted coefficient; o_tap holds its last value.
REQ-025 FLUSH: o_ce=1, o_sample=0 for exactly NTAPS consecutive cycles, then RUN.
REQ-026 RUN: o_ce and o_sample SHALL be i_sample_valid and i_sample registered, latency 1 cycle, no gaps inserted.
REQ-027 i_load_start in RUN SHALL enter LOAD next cycle; in LOAD or FLUSH it SHALL be ignored.
REQ-028 i_sample_valid=1 in IDLE, LOAD or FLUSH SHALL produce o_drop=1 one cycle later; o_drop=0 otherwise.
REQ-029 o_loaded SHALL rise on the cycle RUN is entered and fall on the cycle LOAD is entered.
REQ-030 i_load_start and a final coefficient in the same LOAD cycle: coefficient accepted, start ignored.

Reset
REQ-031 Reset assertion SHALL immediately force IDLE, counter 0, o_tap_wr=0, o_tap=0, o_ce=0, o_sample=0, o_busy=0, o_loaded=0, o_drop=0, o_coef_ready=0.
REQ-032 Reset mid-LOAD or mid-FLUSH SHALL abandon the sequence; o_loaded stays 0 until a full new load completes.

Configuration
REQ-033 Macro FIR_TAP_FLUSH_EN: defined -> FLUSH state present per REQ-025; undefined -> LOAD SHALL go directly to RUN after the NTAPS-th coefficient and FLUSH never occurs.

Verification
REQ-034 Reset, i_load_start, 85 coefficients 0x001..0x055 with i_coef_valid held 1 -> 85 o_tap_wr pulses carrying 0x001..0x055 in order, o_coef_ready drops after 85th.
REQ-035 Same load with i_coef_valid toggling 1/0 -> still exactly 85 writes, values in order, none duplicated.
REQ-036 FIR_TAP_FLUSH_EN defined: after load -> exactly 85 cycles o_ce=1,o_sample=0, then o_loaded=1; undefined -> o_loaded=1 one cycle after last write.
REQ-037 RUN, i_sample=0x7FF valid every cycle, then i_load_start -> o_ce follows with 1-cycle latency, then o_loaded=0 and o_drop=1 per sample while reloading.
REQ-038 i_reset_n asserted after 40 coefficients -> all outputs 0 immediately; subsequent full load of 85 completes normally.
